shared_track_arbiter: RTL and testbench

- Sequences access to the single shared track segment between train A and train B using the six track sensors S1..S6.
- Conditions raw sensor inputs, latches approach requests and grants the segment to one train at a time with round-robin fairness.
- Drives the stop signals and a grant timeout, and detects illegal entries.
- Exports a 4-bit status code and a pass counter for the board's 7-segment display driver.

---
 rtl/track_pkg.sv | 30 +++
 rtl/sensor_conditioner.sv | 54 +++++
 rtl/shared_track_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_shared_track_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/track_pkg.sv
// Shared definitions for the single-segment track arbiter: FSM states,
// sensor slot indices and the served-side marker used for fairness.
package track_pkg;

  localparam logic [3:0] FAULT_CODE = 4'hF;

  // State encoding doubles as the status code shown on the display.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_GRANT_A = 4'd1,
    ST_BUSY_A  = 4'd2,
    ST_GRANT_B = 4'd3,
    ST_BUSY_B  = 4'd4,
    ST_FAULT   = FAULT_CODE
  } state_t;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_t;

  localparam int NUM_SENS    = 6;
  localparam int SENS_A_APP  = 0;
  localparam int SENS_B_APP  = 1;
  localparam int SENS_A_ENT  = 2;
  localparam int SENS_B_ENT  = 3;
  localparam int SENS_A_EXIT = 4;
  localparam int SENS_B_EXIT = 5;

endpackage

// File: rtl/sensor_conditioner.sv
// Conditions one raw track sensor: two-flop synchronizer, a debounce filter
// that only follows a level held for DEB_CYCLES synchronized samples, and a
// one-cycle pulse when the filtered level rises.
module sensor_conditioner #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic sync1;
  logic sync2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous sensor into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive samples disagreeing with the filtered level; flip it once the run is long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          rise  <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/shared_track_arbiter.sv
// Grants the single shared track segment to train A or train B, one at a time,
// with round-robin fairness, a grant timeout, illegal-entry fault detection
// and a traversal counter for the status display.
module shared_track_arbiter
  import track_pkg::*;
#(
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S1,
  input  logic             S2,
  input  logic             S3,
  input  logic             S4,
  input  logic             S5,
  input  logic             S6,
  input  logic             fault_clr,
  output logic             stop_a,
  output logic             stop_b,
  output logic             grant_a,
  output logic             grant_b,
  output logic             fault,
  output logic [3:0]       state_code,
  output logic [CNT_W-1:0] pass_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [NUM_SENS-1:0] raw_vec;
  logic [NUM_SENS-1:0] lvl;
  logic [NUM_SENS-1:0] rise;

  state_t         state;
  state_t         next_state;
  side_t          last_served;
  side_t          next_last;
  logic           req_a;
  logic           req_b;
  logic           want_a;
  logic           want_b;
  logic           clr_req_a;
  logic           clr_req_b;
  logic           tmo_inc;
  logic           pass_inc;
  logic [TW-1:0]  tmo_cnt;

  assign raw_vec = {S6, S5, S4, S3, S2, S1};

  for (genvar i = 0; i < NUM_SENS; i++) begin : g_sens
    sensor_conditioner #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_cond (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_vec[i]),
      .level(lvl[i]),
      .rise (rise[i])
    );
  end

  // An approach edge arriving this very cycle counts as a request so the
  // grant is not delayed by the latch.
  assign want_a = req_a | rise[SENS_A_APP];
  assign want_b = req_b | rise[SENS_B_APP];

  // Next-state decision: entries, exits, timeout and fairness.
  always_comb begin
    next_state = state;
    next_last  = last_served;
    clr_req_a  = 1'b0;
    clr_req_b  = 1'b0;
    tmo_inc    = 1'b0;
    pass_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise[SENS_A_ENT] || rise[SENS_B_ENT]) begin
          next_state = ST_FAULT;
        end else if (want_a && want_b) begin
          next_state = (last_served == SIDE_B) ? ST_GRANT_A : ST_GRANT_B;
        end else if (want_a) begin
          next_state = ST_GRANT_A;
        end else if (want_b) begin
          next_state = ST_GRANT_B;
        end
      end
      ST_GRANT_A: begin
        if (rise[SENS_B_ENT]) begin
          next_state = ST_FAULT;
        end else if (rise[SENS_A_ENT]) begin
          next_state = ST_BUSY_A;
        end else if (tmo_cnt == TMO_LAST) begin
          next_state = ST_IDLE;
          next_last  = SIDE_A;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      ST_BUSY_A: begin
        if (rise[SENS_B_ENT]) begin
          next_state = ST_FAULT;
        end else if (rise[SENS_A_EXIT]) begin
          next_state = ST_IDLE;
          next_last  = SIDE_A;
          clr_req_a  = 1'b1;
          pass_inc   = 1'b1;
        end
      end
      ST_GRANT_B: begin
        if (rise[SENS_A_ENT]) begin
          next_state = ST_FAULT;
        end else if (rise[SENS_B_ENT]) begin
          next_state = ST_BUSY_B;
        end else if (tmo_cnt == TMO_LAST) begin
          next_state = ST_IDLE;
          next_last  = SIDE_B;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      ST_BUSY_B: begin
        if (rise[SENS_A_ENT]) begin
          next_state = ST_FAULT;
        end else if (rise[SENS_B_EXIT]) begin
          next_state = ST_IDLE;
          next_last  = SIDE_B;
          clr_req_b  = 1'b1;
          pass_inc   = 1'b1;
        end
      end
      ST_FAULT: begin
        if (fault_clr && (lvl == '0)) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State, fairness marker, request latches, timeout and pass counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_served <= SIDE_B;
      req_a       <= 1'b0;
      req_b       <= 1'b0;
      tmo_cnt     <= '0;
      pass_cnt    <= '0;
    end else begin
      state       <= next_state;
      last_served <= next_last;
      req_a       <= (req_a | rise[SENS_A_APP]) & ~clr_req_a;
      req_b       <= (req_b | rise[SENS_B_APP]) & ~clr_req_b;
      tmo_cnt     <= tmo_inc ? tmo_cnt + 1'b1 : '0;
      if (pass_inc) begin
        pass_cnt <= pass_cnt + 1'b1;
      end
    end
  end

  // Signal outputs registered from the next state so they change with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_a  <= 1'b1;
      stop_b  <= 1'b1;
      grant_a <= 1'b0;
      grant_b <= 1'b0;
      fault   <= 1'b0;
    end else begin
      grant_a <= (next_state == ST_GRANT_A) || (next_state == ST_BUSY_A);
      grant_b <= (next_state == ST_GRANT_B) || (next_state == ST_BUSY_B);
      stop_a  <= !((next_state == ST_GRANT_A) || (next_state == ST_BUSY_A));
      stop_b  <= !((next_state == ST_GRANT_B) || (next_state == ST_BUSY_B));
      fault   <= (next_state == ST_FAULT);
    end
  end

  assign state_code = state;

endmodule

// File: tb/tb_shared_track_arbiter.sv
// Self-checking bench for shared_track_arbiter: a vector table of directed
// steps, hand-written multi-cycle sequences, then random sensor activity
// compared cycle by cycle against a behavioural model of the arbiter.
module tb_shared_track_arbiter;

  localparam int DEB = 4;
  localparam int TMO = 50;
  localparam int CW  = 8;
  localparam int RAND_CYCLES = 4000;

  logic          clk;
  logic          rst_n;
  logic [5:0]    sens;
  logic          fault_clr;
  logic          stop_a;
  logic          stop_b;
  logic          grant_a;
  logic          grant_b;
  logic          fault;
  logic [3:0]    state_code;
  logic [CW-1:0] pass_cnt;

  int checks;
  int passed;

  shared_track_arbiter #(
    .DEB_CYCLES    (DEB),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .S1        (sens[0]),
    .S2        (sens[1]),
    .S3        (sens[2]),
    .S4        (sens[3]),
    .S5        (sens[4]),
    .S6        (sens[5]),
    .fault_clr (fault_clr),
    .stop_a    (stop_a),
    .stop_b    (stop_b),
    .grant_a   (grant_a),
    .grant_b   (grant_b),
    .fault     (fault),
    .state_code(state_code),
    .pass_cnt  (pass_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One directed step: drive sensors and clear, wait, then expect these outputs.
  typedef struct {
    bit         rst;
    logic [5:0] sens;
    logic       clr;
    int         hold;
    logic [3:0] code;
    logic       sa;
    logic       sb;
    logic       flt;
    int         pass;
  } vec_t;

  vec_t tbl[20];

  // Behavioural model: raw sample history per sensor, conditioned levels and
  // rise flags, plus the arbiter's abstract state.
  logic m_hist[6][DEB+2];
  logic m_lvl[6];
  logic m_rise[6];
  int   m_state;
  bit   m_last_b;
  bit   m_req[2];
  int   m_grant_cycles;
  int   m_pass;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < DEB + 2; k++) m_hist[s][k] = 1'b0;
      m_lvl[s]  = 1'b0;
      m_rise[s] = 1'b0;
    end
    m_state        = 0;
    m_last_b       = 1'b1;
    m_req[0]       = 1'b0;
    m_req[1]       = 1'b0;
    m_grant_cycles = 0;
    m_pass         = 0;
  endtask

  task automatic doReset();
    sens      = '0;
    fault_clr = 1'b0;
    rst_n     = 1'b0;
    tick(2);
    rst_n = 1'b1;
    modelReset();
  endtask

  // Advance the model by one clock edge given the inputs present at that edge.
  task automatic modelStep(input logic [5:0] raw, input logic clr);
    bit want_a;
    bit want_b;
    bit clr_req[2];
    bit all_low;
    bit flip;
    int nxt;
    int side;
    want_a     = m_req[0] | m_rise[0];
    want_b     = m_req[1] | m_rise[1];
    clr_req[0] = 1'b0;
    clr_req[1] = 1'b0;
    nxt        = m_state;
    all_low    = 1'b1;
    for (int s = 0; s < 6; s++) if (m_lvl[s]) all_low = 1'b0;
    case (m_state)
      0: begin
        if (m_rise[2] || m_rise[3]) nxt = 15;
        else if (want_a && (!want_b || m_last_b)) nxt = 1;
        else if (want_b) nxt = 3;
      end
      1, 3: begin
        side = (m_state == 3) ? 1 : 0;
        if (m_rise[3 - side]) nxt = 15;
        else if (m_rise[2 + side]) nxt = m_state + 1;
        else if (m_grant_cycles + 1 >= TMO) begin
          nxt      = 0;
          m_last_b = (side == 1);
        end
      end
      2, 4: begin
        side = (m_state == 4) ? 1 : 0;
        if (m_rise[3 - side]) nxt = 15;
        else if (m_rise[4 + side]) begin
          nxt           = 0;
          m_last_b      = (side == 1);
          clr_req[side] = 1'b1;
          m_pass        = (m_pass + 1) % (1 << CW);
        end
      end
      default: begin
        if (clr && all_low) nxt = 0;
      end
    endcase
    if ((nxt == 1 || nxt == 3) && nxt == m_state) m_grant_cycles++;
    else m_grant_cycles = 0;
    m_state = nxt;
    for (int i = 0; i < 2; i++) m_req[i] = (m_req[i] | m_rise[i]) & ~clr_req[i];
    for (int s = 0; s < 6; s++) begin
      for (int k = DEB + 1; k > 0; k--) m_hist[s][k] = m_hist[s][k-1];
      m_hist[s][0] = raw[s];
      flip = 1'b1;
      for (int k = 2; k < DEB + 2; k++) if (m_hist[s][k] == m_lvl[s]) flip = 1'b0;
      if (flip) m_lvl[s] = ~m_lvl[s];
      m_rise[s] = flip & m_lvl[s];
    end
  endtask

  task automatic applyStimulus(input logic [5:0] s, input logic clr, input int hold);
    sens      = s;
    fault_clr = clr;
    tick(hold);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] code,
                             input logic sa, input logic sb, input logic flt, input int pass);
    logic ga;
    logic gb;
    logic [CW-1:0] p;
    ga = (code == 4'd1) || (code == 4'd2);
    gb = (code == 4'd3) || (code == 4'd4);
    p  = CW'(pass);
    checks++;
    if ({state_code, stop_a, stop_b, grant_a, grant_b, fault, pass_cnt} ===
        {code, sa, sb, ga, gb, flt, p}) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got code=%h stop=%b%b grant=%b%b fault=%b pass=%0d, expected code=%h stop=%b%b grant=%b%b fault=%b pass=%0d",
               name, state_code, stop_a, stop_b, grant_a, grant_b, fault, pass_cnt,
               code, sa, sb, ga, gb, flt, p);
    end
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    rst_n     = 1'b0;
    sens      = '0;
    fault_clr = 1'b0;

    // Directed traversal / fairness / illegal-entry steps.
    tbl[0]  = '{1'b1, 6'h00, 1'b0,  2, 4'h0, 1'b1, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b0, 6'h01, 1'b0, 10, 4'h1, 1'b0, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b0, 6'h00, 1'b0, 10, 4'h1, 1'b0, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b0, 6'h04, 1'b0, 10, 4'h2, 1'b0, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b0, 6'h00, 1'b0, 10, 4'h2, 1'b0, 1'b1, 1'b0, 0};
    tbl[5]  = '{1'b0, 6'h10, 1'b0, 10, 4'h0, 1'b1, 1'b1, 1'b0, 1};
    tbl[6]  = '{1'b0, 6'h00, 1'b0, 10, 4'h0, 1'b1, 1'b1, 1'b0, 1};
    tbl[7]  = '{1'b1, 6'h03, 1'b0, 10, 4'h1, 1'b0, 1'b1, 1'b0, 0};
    tbl[8]  = '{1'b0, 6'h04, 1'b0, 10, 4'h2, 1'b0, 1'b1, 1'b0, 0};
    tbl[9]  = '{1'b0, 6'h00, 1'b0, 10, 4'h2, 1'b0, 1'b1, 1'b0, 0};
    tbl[10] = '{1'b0, 6'h10, 1'b0, 10, 4'h3, 1'b1, 1'b0, 1'b0, 1};
    tbl[11] = '{1'b0, 6'h08, 1'b0, 10, 4'h4, 1'b1, 1'b0, 1'b0, 1};
    tbl[12] = '{1'b0, 6'h00, 1'b0, 10, 4'h4, 1'b1, 1'b0, 1'b0, 1};
    tbl[13] = '{1'b0, 6'h20, 1'b0, 10, 4'h0, 1'b1, 1'b1, 1'b0, 2};
    tbl[14] = '{1'b1, 6'h01, 1'b0, 10, 4'h1, 1'b0, 1'b1, 1'b0, 0};
    tbl[15] = '{1'b0, 6'h04, 1'b0, 10, 4'h2, 1'b0, 1'b1, 1'b0, 0};
    tbl[16] = '{1'b0, 6'h0C, 1'b0, 10, 4'hF, 1'b1, 1'b1, 1'b1, 0};
    tbl[17] = '{1'b0, 6'h04, 1'b1, 10, 4'hF, 1'b1, 1'b1, 1'b1, 0};
    tbl[18] = '{1'b0, 6'h00, 1'b1,  7, 4'h0, 1'b1, 1'b1, 1'b0, 0};
    tbl[19] = '{1'b0, 6'h00, 1'b0,  1, 4'h1, 1'b0, 1'b1, 1'b0, 0};

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].rst) doReset();
      applyStimulus(tbl[i].sens, tbl[i].clr, tbl[i].hold);
      checkOutput($sformatf("table_%0d", i), tbl[i].code, tbl[i].sa, tbl[i].sb,
                  tbl[i].flt, tbl[i].pass);
    end

    // Exact grant latency, then timeout of A with B pending, then timeout of B.
    doReset();
    applyStimulus(6'h01, 1'b0, 6);
    checkOutput("latency_6clk", 4'h0, 1'b1, 1'b1, 1'b0, 0);
    applyStimulus(6'h01, 1'b0, 1);
    checkOutput("latency_7clk", 4'h1, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(6'h02, 1'b0, 49);
    checkOutput("tmo_a_held", 4'h1, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(6'h00, 1'b0, 1);
    checkOutput("tmo_a_idle", 4'h0, 1'b1, 1'b1, 1'b0, 0);
    applyStimulus(6'h00, 1'b0, 1);
    checkOutput("tmo_b_grant", 4'h3, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(6'h00, 1'b0, 49);
    checkOutput("tmo_b_held", 4'h3, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(6'h00, 1'b0, 1);
    checkOutput("tmo_b_idle", 4'h0, 1'b1, 1'b1, 1'b0, 0);
    applyStimulus(6'h00, 1'b0, 1);
    checkOutput("req_a_retained", 4'h1, 1'b0, 1'b1, 1'b0, 0);

    // Short S2 glitches are rejected; a four-sample pulse is accepted.
    doReset();
    for (int g = 1; g <= 3; g++) begin
      applyStimulus(6'h02, 1'b0, g);
      applyStimulus(6'h00, 1'b0, 10);
      checkOutput($sformatf("glitch_%0d", g), 4'h0, 1'b1, 1'b1, 1'b0, 0);
    end
    applyStimulus(6'h02, 1'b0, 4);
    applyStimulus(6'h00, 1'b0, 10);
    checkOutput("stable_4", 4'h3, 1'b1, 1'b0, 1'b0, 0);

    // Asynchronous reset while B is on the segment.
    doReset();
    applyStimulus(6'h02, 1'b0, 10);
    applyStimulus(6'h08, 1'b0, 10);
    applyStimulus(6'h20, 1'b0, 10);
    checkOutput("b_pass", 4'h0, 1'b1, 1'b1, 1'b0, 1);
    applyStimulus(6'h02, 1'b0, 10);
    applyStimulus(6'h08, 1'b0, 10);
    checkOutput("busy_b", 4'h4, 1'b1, 1'b0, 1'b0, 1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 4'h0, 1'b1, 1'b1, 1'b0, 0);

    // Random sensor activity against the model.
    doReset();
    for (int c = 0; c < RAND_CYCLES; c++) begin
      for (int s = 0; s < 6; s++) begin
        if ($urandom_range(0, 9) == 0) sens[s] = ~sens[s];
      end
      if ($urandom_range(0, 199) == 0) sens = '0;
      fault_clr = ($urandom_range(0, 3) == 0);
      tick(1);
      modelStep(sens, fault_clr);
      checkOutput($sformatf("random_%0d", c), 4'(m_state),
                  !(m_state == 1 || m_state == 2),
                  !(m_state == 3 || m_state == 4),
                  (m_state == 15), m_pass);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
